// File: rtl/pipe_fetch_unit.sv
// Fetch stage: byte-addressed PC, one-cycle synchronous instruction memory,
// show-ahead prefetch FIFO toward decode, and redirect with full flush.
module pipe_fetch_unit #(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter int unsigned            DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0,
    parameter int unsigned            PC_STEP    = 4
) (
    input  logic                          clk1,
    input  logic                          reset1,
    output logic                          imem_req,
    output logic [ADDR_WIDTH-1:0]         imem_addr,
    input  logic [31:0]                   imem_rdata,
    output logic                          instr_valid,
    output logic [31:0]                   instr,
    output logic [ADDR_WIDTH-1:0]         instr_pc,
    input  logic                          instr_ready,
    input  logic                          redirect_en,
    input  logic [ADDR_WIDTH-1:0]         redirect_pc,
    output logic [$clog2(DEPTH+1)-1:0]    fifo_count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned OW = CW + 1;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("pipe_fetch_unit: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] inflight_pc;
    logic                  inflight;
    logic [CW-1:0]         count;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [31:0]           instr_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem    [DEPTH];

    logic          pop;
    logic          push;
    logic          credit;
    logic [OW-1:0] occupancy;

    // Credit counts the in-flight response and lets a same-cycle pop free a slot.
    always_comb begin
        pop         = 1'b0;
        push        = 1'b0;
        credit      = 1'b0;
        occupancy   = '0;
        instr_valid = (count != '0) && !redirect_en;
        pop         = instr_valid && instr_ready;
        push        = inflight && !redirect_en;
        occupancy   = OW'(count) + OW'(inflight) - OW'(pop);
        credit      = occupancy < OW'(DEPTH);
        imem_req    = !reset1 && !redirect_en && credit;
    end

    assign imem_addr  = fetch_pc;
    assign instr      = instr_mem[rd_ptr];
    assign instr_pc   = pc_mem[rd_ptr];
    assign fifo_count = count;

    // Control state; redirect wins over request, push and pop.
    always_ff @(posedge clk1 or posedge reset1) begin
        if (reset1) begin
            fetch_pc    <= RESET_PC;
            inflight_pc <= RESET_PC;
            inflight    <= 1'b0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (redirect_en) begin
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                fetch_pc    <= fetch_pc + ADDR_WIDTH'(PC_STEP);
                inflight_pc <= fetch_pc;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // FIFO payload storage needs no reset; entries are qualified by count.
    always_ff @(posedge clk1) begin
        if (push) begin
            instr_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]    <= inflight_pc;
        end
    end

endmodule

// File: tb/tb_pipe_fetch_unit.sv
// Directed bench for pipe_fetch_unit: a 32-bit DEPTH=4 instance driven from a
// vector table and hand sequences, plus an 8-bit instance for PC wrap-around.
module tb_pipe_fetch_unit;

    localparam int unsigned AW  = 32;
    localparam int unsigned BAW = 8;

    logic          clk1 = 1'b0;
    logic          reset1;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic          instr_valid;
    logic [31:0]   instr;
    logic [AW-1:0] instr_pc;
    logic          instr_ready;
    logic          redirect_en;
    logic [AW-1:0] redirect_pc;
    logic [2:0]    fifo_count;

    logic           b_reset;
    logic           b_req;
    logic [BAW-1:0] b_addr;
    logic [31:0]    b_rdata;
    logic           b_valid;
    logic [31:0]    b_instr;
    logic [BAW-1:0] b_pc;
    logic           b_ready;
    logic           b_redir;
    logic [BAW-1:0] b_rpc;
    logic [2:0]     b_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk1 = ~clk1;

    pipe_fetch_unit #(.ADDR_WIDTH(AW), .DEPTH(4), .RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clk1(clk1), .reset1(reset1),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .fifo_count(fifo_count)
    );

    pipe_fetch_unit #(.ADDR_WIDTH(BAW), .DEPTH(4), .RESET_PC(8'h40), .PC_STEP(4)) dut_b (
        .clk1(clk1), .reset1(b_reset),
        .imem_req(b_req), .imem_addr(b_addr), .imem_rdata(b_rdata),
        .instr_valid(b_valid), .instr(b_instr), .instr_pc(b_pc),
        .instr_ready(b_ready), .redirect_en(b_redir), .redirect_pc(b_rpc),
        .fifo_count(b_count)
    );

    function automatic logic [31:0] tag_a(input logic [31:0] pc);
        return 32'hC0DE_0000 ^ pc;
    endfunction

    function automatic logic [31:0] tag_b(input logic [7:0] pc);
        return {24'h5A5A5A, pc};
    endfunction

    // Instruction memory models: data returned one cycle after the request.
    always @(posedge clk1) if (imem_req) imem_rdata <= tag_a(imem_addr);
    always @(posedge clk1) if (b_req) b_rdata <= tag_b(b_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] ready;
        logic [31:0] redir;
        logic [31:0] rpc;
        logic [31:0] req;
        logic [31:0] addr;
        logic [31:0] valid;
        logic [31:0] pc;
        logic [31:0] cnt;
    } vec_t;

    vec_t vt [25];
    int   nv = 0;

    task automatic add(input logic [31:0] ready, input logic [31:0] redir, input logic [31:0] rpc,
                       input logic [31:0] req, input logic [31:0] addr, input logic [31:0] valid,
                       input logic [31:0] pc, input logic [31:0] cnt);
        vt[nv] = '{ready, redir, rpc, req, addr, valid, pc, cnt};
        nv++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] reqs [$];
        logic [31:0] exp_pc;

        reset1      = 1'b1;
        instr_ready = 1'b1;
        redirect_en = 1'b0;
        redirect_pc = '0;
        b_reset     = 1'b1;
        b_ready     = 1'b1;
        b_redir     = 1'b0;
        b_rpc       = '0;

        // Streaming, redirect mid-stream, backpressure, redirect on full FIFO, held redirect.
        //  ready redir rpc     req addr    valid pc      cnt
        add(1, 0, 0,       1, 'h000, 0, 0,      0);
        add(1, 0, 0,       1, 'h004, 0, 0,      0);
        add(1, 0, 0,       1, 'h008, 1, 'h000, 1);
        add(1, 0, 0,       1, 'h00C, 1, 'h004, 1);
        add(1, 0, 0,       1, 'h010, 1, 'h008, 1);
        add(1, 1, 'h100,   0, 'h014, 0, 0,      1);
        add(1, 0, 0,       1, 'h100, 0, 0,      0);
        add(1, 0, 0,       1, 'h104, 0, 0,      0);
        add(1, 0, 0,       1, 'h108, 1, 'h100, 1);
        add(1, 0, 0,       1, 'h10C, 1, 'h104, 1);
        add(0, 0, 0,       1, 'h110, 1, 'h108, 1);
        add(0, 0, 0,       1, 'h114, 1, 'h108, 2);
        add(0, 0, 0,       0, 'h118, 1, 'h108, 3);
        add(0, 0, 0,       0, 'h118, 1, 'h108, 4);
        add(0, 0, 0,       0, 'h118, 1, 'h108, 4);
        add(1, 1, 'h200,   0, 'h118, 0, 0,      4);
        add(1, 0, 0,       1, 'h200, 0, 0,      0);
        add(1, 0, 0,       1, 'h204, 0, 0,      0);
        add(1, 0, 0,       1, 'h208, 1, 'h200, 1);
        add(1, 0, 0,       1, 'h20C, 1, 'h204, 1);
        add(1, 1, 'h300,   0, 'h210, 0, 0,      1);
        add(1, 1, 'h340,   0, 'h300, 0, 0,      0);
        add(1, 0, 0,       1, 'h340, 0, 0,      0);
        add(1, 0, 0,       1, 'h344, 0, 0,      0);
        add(1, 0, 0,       1, 'h348, 1, 'h340, 1);

        // Reset values.
        @(negedge clk1);
        #1;
        chk("rst_req",   32'(imem_req),    32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_count", 32'(fifo_count),  32'h0);
        chk("rst_addr",  imem_addr,        32'h0);
        chk("rst_addr_b", 32'(b_addr),     32'h40);
        @(negedge clk1);

        reset1 = 1'b0;
        for (int i = 0; i < nv; i++) begin
            instr_ready = vt[i].ready[0];
            redirect_en = vt[i].redir[0];
            redirect_pc = vt[i].rpc;
            #1;
            chk($sformatf("v%0d_req", i),   32'(imem_req),    vt[i].req);
            chk($sformatf("v%0d_addr", i),  imem_addr,        vt[i].addr);
            chk($sformatf("v%0d_valid", i), 32'(instr_valid), vt[i].valid);
            chk($sformatf("v%0d_count", i), 32'(fifo_count),  vt[i].cnt);
            if (vt[i].valid[0]) begin
                chk($sformatf("v%0d_pc", i),    instr_pc, vt[i].pc);
                chk($sformatf("v%0d_instr", i), instr,    tag_a(vt[i].pc));
            end
            @(negedge clk1);
        end

        // Backpressure from cold start: exactly four requests, then drain in order.
        reset1      = 1'b1;
        instr_ready = 1'b0;
        redirect_en = 1'b0;
        @(negedge clk1);
        reset1 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (imem_req) reqs.push_back(imem_addr);
            @(negedge clk1);
        end
        chk("bp_nreq", 32'(reqs.size()), 32'd4);
        for (int k = 0; k < reqs.size() && k < 4; k++)
            chk($sformatf("bp_req%0d", k), reqs[k], 32'(k * 4));
        #1;
        chk("bp_count_full", 32'(fifo_count), 32'd4);
        chk("bp_req_stall",  32'(imem_req),   32'h0);
        instr_ready = 1'b1;
        #1;
        chk("bp_reissue", 32'(imem_req), 32'h1);
        for (int k = 0; k < 5; k++) begin
            exp_pc = 32'(k * 4);
            if (k != 0) #2;
            chk($sformatf("bp_pop%0d_valid", k), 32'(instr_valid), 32'h1);
            chk($sformatf("bp_pop%0d_pc", k),    instr_pc,         exp_pc);
            chk($sformatf("bp_pop%0d_instr", k), instr,            tag_a(exp_pc));
            @(negedge clk1);
        end

        // Asynchronous reset with three entries buffered.
        reset1      = 1'b1;
        instr_ready = 1'b0;
        @(negedge clk1);
        reset1 = 1'b0;
        repeat (4) @(negedge clk1);
        #1;
        chk("ar_count_pre", 32'(fifo_count), 32'd3);
        #2;
        reset1 = 1'b1;
        #1;
        chk("ar_req",   32'(imem_req),    32'h0);
        chk("ar_valid", 32'(instr_valid), 32'h0);
        chk("ar_count", 32'(fifo_count),  32'h0);
        chk("ar_addr",  imem_addr,        32'h0);
        @(negedge clk1);
        reset1      = 1'b0;
        instr_ready = 1'b1;
        #1;
        chk("ar_c0_req",  32'(imem_req), 32'h1);
        chk("ar_c0_addr", imem_addr,     32'h0);
        @(negedge clk1);
        #1;
        chk("ar_c1_valid", 32'(instr_valid), 32'h0);
        chk("ar_c1_addr",  imem_addr,        32'h4);
        @(negedge clk1);
        #1;
        chk("ar_c2_valid", 32'(instr_valid), 32'h1);
        chk("ar_c2_pc",    instr_pc,         32'h0);
        chk("ar_c2_instr", instr,            tag_a(32'h0));
        @(negedge clk1);

        // 8-bit PC wrap-around after a redirect to 0xF8.
        b_reset = 1'b0;
        b_redir = 1'b1;
        b_rpc   = 8'hF8;
        #1;
        chk("wr_c0_req", 32'(b_req), 32'h0);
        @(negedge clk1);
        b_redir = 1'b0;
        #1;
        chk("wr_c1_req",  32'(b_req),  32'h1);
        chk("wr_c1_addr", 32'(b_addr), 32'hF8);
        @(negedge clk1);
        @(negedge clk1);
        for (int k = 0; k < 4; k++) begin
            logic [7:0] wpc;
            wpc = 8'hF8 + 8'(k * 4);
            #1;
            chk($sformatf("wr%0d_valid", k), 32'(b_valid), 32'h1);
            chk($sformatf("wr%0d_pc", k),    32'(b_pc),    32'(wpc));
            chk($sformatf("wr%0d_instr", k), b_instr,      tag_b(wpc));
            @(negedge clk1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
